// File: rtl/sys_prog_loader_if.sv
// ---------------------------------------------------------------------------
// sys_prog_loader_if
//   Bundles the byte-stream and memory-side signals of sys_prog_loader.
//
//   Handshakes (valid/ready): a transfer happens on the rising CLK edge where
//   valid && ready are both 1. The sender holds valid and data stable until
//   that edge. Valid never depends combinationally on ready.
//
//   rx_valid/rx_data/rx_ready : inbound program image bytes
//   tx_valid/tx_data/tx_ready : outbound memory dump bytes
//   tbCTRL                    : 1 = loader owns memory, CPU held
//   WEN/REN/addr/store/load   : single-port memory access (byte address)
//   halt                      : CPU reports it has halted
//
//   master = loader side, slave = memory/stream environment side.
// ---------------------------------------------------------------------------
interface sys_prog_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tbCTRL;
  logic        WEN;
  logic        REN;
  logic [31:0] addr;
  logic [31:0] store;
  logic [31:0] load;
  logic        halt;

  modport master (
    input  rx_valid, rx_data, tx_ready, load, halt,
    output rx_ready, tx_valid, tx_data, tbCTRL, WEN, REN, addr, store
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, load, halt,
    input  rx_ready, tx_valid, tx_data, tbCTRL, WEN, REN, addr, store
  );
endinterface

// File: rtl/sys_prog_loader.sv
// ---------------------------------------------------------------------------
// sys_prog_loader
//   Loads a program image (2-byte LE word count N, then 4N bytes, words LE)
//   into memory while holding the CPU, releases the CPU until halt, then reads
//   back DUMP_WORDS words from DUMP_BASE and streams them out as LE bytes.
//
//   Optional feature macro: SYS_LOADER_CSUM_EN -- when defined, one extra
//   byte (XOR of every dumped byte) is sent after the last dump byte.
//
// Ports:
//   CLK, nRST   clock, asynchronous active-low reset
//   bus         sys_prog_loader_if.master (rx/tx byte streams, memory bus,
//               tbCTRL, halt)
//   done        dump complete, sticky until reset
//   dbgState    current FSM state encoding
// ---------------------------------------------------------------------------
module sys_prog_loader #(
  parameter logic [31:0] LOAD_BASE  = 32'h0000_0000,
  parameter logic [31:0] DUMP_BASE  = 32'h0000_0000,
  parameter int unsigned DUMP_WORDS = 256,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                     CLK,
  input  logic                     nRST,
  sys_prog_loader_if.master        bus,
  output logic                     done,
  output logic [3:0]               dbgState
);

  typedef enum logic [3:0] {
    HDR0    = 4'd0,
    HDR1    = 4'd1,
    LOAD    = 4'd2,
    WRITE   = 4'd3,
    RUN     = 4'd4,
    DUMP_RD = 4'd5,
    DUMP_TX = 4'd6,
    CSUM    = 4'd7,
    DONE    = 4'd8
  } stateT;

  stateT       state, stateNext;
  logic        rxEn;
  logic        rxReady, rxFire, txFire;
  logic [15:0] wordCnt, wordCntNext;
  logic [15:0] wIdx, wIdxNext;
  logic [1:0]  bCnt, bCntNext;
  logic [31:0] loadWord, loadWordNext;
  logic [31:0] dumpWord, dumpWordNext;
  logic [31:0] rIdx, rIdxNext;
  logic [31:0] latCnt, latCntNext;
  logic [31:0] addrQ, addrNext;
  logic [31:0] storeQ, storeNext;
`ifdef SYS_LOADER_CSUM_EN
  logic [7:0]  csum, csumNext;
`endif

  // rx_ready must read 0 during reset even though HDR0 accepts bytes, so it
  // is gated by a flag that only rises on the first clock after reset.
  assign rxReady        = rxEn && (state == HDR0 || state == HDR1 || state == LOAD);
  assign rxFire         = bus.rx_valid && rxReady;
  assign txFire         = bus.tx_valid && bus.tx_ready;
  assign bus.rx_ready   = rxReady;
  assign bus.addr       = addrQ;
  assign bus.store      = storeQ;
  assign dbgState       = state;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= HDR0;
      rxEn     <= 1'b0;
      wordCnt  <= '0;
      wIdx     <= '0;
      bCnt     <= '0;
      loadWord <= '0;
      dumpWord <= '0;
      rIdx     <= '0;
      latCnt   <= '0;
      addrQ    <= '0;
      storeQ   <= '0;
`ifdef SYS_LOADER_CSUM_EN
      csum     <= '0;
`endif
    end else begin
      state    <= stateNext;
      rxEn     <= 1'b1;
      wordCnt  <= wordCntNext;
      wIdx     <= wIdxNext;
      bCnt     <= bCntNext;
      loadWord <= loadWordNext;
      dumpWord <= dumpWordNext;
      rIdx     <= rIdxNext;
      latCnt   <= latCntNext;
      addrQ    <= addrNext;
      storeQ   <= storeNext;
`ifdef SYS_LOADER_CSUM_EN
      csum     <= csumNext;
`endif
    end
  end

  always_comb begin
    // Moore outputs
    bus.tbCTRL   = (state != RUN);
    bus.WEN      = (state == WRITE);
    bus.REN      = (state == DUMP_RD);
    done         = (state == DONE);
`ifdef SYS_LOADER_CSUM_EN
    bus.tx_valid = (state == DUMP_TX) || (state == CSUM);
    bus.tx_data  = (state == CSUM) ? csum : dumpWord[7:0];
`else
    bus.tx_valid = (state == DUMP_TX);
    bus.tx_data  = dumpWord[7:0];
`endif

    stateNext    = state;
    wordCntNext  = wordCnt;
    wIdxNext     = wIdx;
    bCntNext     = bCnt;
    loadWordNext = loadWord;
    dumpWordNext = dumpWord;
    rIdxNext     = rIdx;
    latCntNext   = latCnt;
    addrNext     = addrQ;
    storeNext    = storeQ;
`ifdef SYS_LOADER_CSUM_EN
    csumNext     = csum;
`endif

    case (state)
      HDR0: if (rxFire) begin
        wordCntNext[7:0] = bus.rx_data;
        stateNext        = HDR1;
      end
      HDR1: if (rxFire) begin
        wordCntNext[15:8] = bus.rx_data;
        wIdxNext          = '0;
        bCntNext          = '0;
        stateNext         = ({bus.rx_data, wordCnt[7:0]} == 16'd0) ? RUN : LOAD;
      end
      LOAD: if (rxFire) begin
        // Shift right so the first byte of a word ends up in bits 7:0.
        loadWordNext = {bus.rx_data, loadWord[31:8]};
        bCntNext     = bCnt + 2'd1;
        if (bCnt == 2'd3) begin
          addrNext  = LOAD_BASE + {14'd0, wIdx, 2'b00};
          storeNext = {bus.rx_data, loadWord[31:8]};
          stateNext = WRITE;
        end
      end
      WRITE: begin
        wIdxNext  = wIdx + 16'd1;
        stateNext = (wIdx == wordCnt - 16'd1) ? RUN : LOAD;
      end
      RUN: if (bus.halt) begin
        rIdxNext   = '0;
        latCntNext = '0;
        addrNext   = DUMP_BASE;
        stateNext  = DUMP_RD;
      end
      DUMP_RD: begin
        if (latCnt == 32'(RD_LAT - 1)) begin
          dumpWordNext = bus.load;
          latCntNext   = '0;
          bCntNext     = '0;
          stateNext    = DUMP_TX;
        end else begin
          latCntNext = latCnt + 32'd1;
        end
      end
      DUMP_TX: if (txFire) begin
        dumpWordNext = {8'h00, dumpWord[31:8]};
        bCntNext     = bCnt + 2'd1;
`ifdef SYS_LOADER_CSUM_EN
        csumNext     = csum ^ dumpWord[7:0];
`endif
        if (bCnt == 2'd3) begin
          rIdxNext = rIdx + 32'd1;
          if (rIdx == 32'(DUMP_WORDS - 1)) begin
`ifdef SYS_LOADER_CSUM_EN
            stateNext = CSUM;
`else
            stateNext = DONE;
`endif
          end else begin
            addrNext  = DUMP_BASE + {rIdxNext[29:0], 2'b00};
            stateNext = DUMP_RD;
          end
        end
      end
`ifdef SYS_LOADER_CSUM_EN
      CSUM: if (txFire) stateNext = DONE;
`endif
      DONE: stateNext = DONE;
      default: stateNext = HDR0;
    endcase
  end

endmodule

// File: tb/tb_sys_prog_loader.sv
module tb_sys_prog_loader;
  localparam logic [31:0] LOAD_BASE_P  = 32'h0000_0100;
  localparam logic [31:0] DUMP_BASE_P  = 32'h0000_0000;
  localparam int          DUMP_WORDS_P = 2;
  localparam int          RD_LAT_P     = 2;

  localparam logic [3:0] S_RUN     = 4'd4;
  localparam logic [3:0] S_DUMP_RD = 4'd5;
  localparam logic [3:0] S_DONE    = 4'd8;

  // ---------------- clock / reset ----------------
  logic       CLK;
  logic       nRST;
  logic       done;
  logic [3:0] dbgState;

  sys_prog_loader_if bus();

  sys_prog_loader #(
    .LOAD_BASE(LOAD_BASE_P), .DUMP_BASE(DUMP_BASE_P),
    .DUMP_WORDS(DUMP_WORDS_P), .RD_LAT(RD_LAT_P)
  ) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus.master), .done(done), .dbgState(dbgState)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // ---------------- memory model ----------------
  logic [31:0] mem [0:1023];
  always @(posedge CLK) if (bus.WEN) mem[bus.addr[11:2]] <= bus.store;
  assign bus.load = mem[bus.addr[11:2]];

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];   // {addr, data} of expected writes
  logic [7:0]  tx_q[$];    // expected outbound bytes
  logic [31:0] exp_rd;
  int          ren_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    logic [63:0] e;
    if (nRST) begin
      if (bus.WEN || bus.REN) begin
        chk("strobe_exclusive", {31'd0, bus.WEN && bus.REN}, 32'd0);
        chk("strobe_owned", {31'd0, bus.tbCTRL}, 32'd1);
      end
      if (bus.WEN) begin
        if (exp_q.size() == 0) chk("wen_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.addr, e[63:32]);
          chk("wr_data", bus.store, e[31:0]);
        end
      end
      if (bus.REN) begin
        ren_run++;
        if (ren_run == 1) chk("rd_addr", bus.addr, exp_rd);
      end else if (ren_run > 0) begin
        chk("rd_len", ren_run, RD_LAT_P);
        exp_rd  = exp_rd + 32'd4;
        ren_run = 0;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (tx_q.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
        else chk("tx_byte", {24'd0, bus.tx_data}, {24'd0, tx_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_values();
    chk("rst_tbCTRL", {31'd0, bus.tbCTRL}, 32'd1);
    chk("rst_WEN", {31'd0, bus.WEN}, 32'd0);
    chk("rst_REN", {31'd0, bus.REN}, 32'd0);
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_store", bus.store, 32'd0);
    chk("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_state", {28'd0, dbgState}, 32'd0);
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;
    bus.halt     = 1'b0;
    nRST         = 1'b0;
    #1;
    check_reset_values();
    ren_run = 0;
    exp_rd  = DUMP_BASE_P;
    tick();
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.rx_ready) chk("rx_timeout", 32'd0, 32'd1);
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    if (gap) tick();
  endtask

  // Sends a whole word; the final byte is sent without a trailing gap when
  // last is set so the caller lands exactly in the write cycle.
  task automatic send_word(input logic [31:0] w, input bit gap, input bit last);
    logic [31:0] v = w;
    for (int k = 0; k < 4; k++) begin
      send_byte(v[7:0], (k == 3 && last) ? 1'b0 : gap);
      v = v >> 8;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    bit          gap;
  } vec_t;

  vec_t vecs[3];

  initial begin
    logic [31:0] words [3];
    logic [7:0]  d0;
    int          nb;
    int          n;

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'hAABBCCDD;
    mem[1] = 32'h01020304;

    vecs[0] = '{n: 1, w0: 32'h12345678, w1: 32'h0,        w2: 32'h0,        gap: 1'b0};
    vecs[1] = '{n: 3, w0: 32'hDEADBEEF, w1: 32'h00FF00FF, w2: 32'h80000001, gap: 1'b1};
    vecs[2] = '{n: 2, w0: 32'hFFFFFFFF, w1: 32'h0A0B0C0D, w2: 32'h0,        gap: 1'b0};

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;
    bus.halt     = 1'b0;
    nRST         = 1'b1;
    #2;

    // Table-driven image loads
    foreach (vecs[v]) begin
      do_reset();
      words[0] = vecs[v].w0;
      words[1] = vecs[v].w1;
      words[2] = vecs[v].w2;
      send_byte(vecs[v].n[7:0], vecs[v].gap);
      send_byte(vecs[v].n[15:8], vecs[v].gap);
      for (int i = 0; i < vecs[v].n; i++) begin
        exp_q.push_back({LOAD_BASE_P + 32'(4 * i), words[i]});
        send_word(words[i], vecs[v].gap, i == vecs[v].n - 1);
        if (i < vecs[v].n - 1) chk("load_tbCTRL", {31'd0, bus.tbCTRL}, 32'd1);
      end
      chk("last_wen", {31'd0, bus.WEN}, 32'd1);
      chk("last_tbCTRL_hi", {31'd0, bus.tbCTRL}, 32'd1);
      tick();
      chk("run_tbCTRL_lo", {31'd0, bus.tbCTRL}, 32'd0);
      chk("run_wen_lo", {31'd0, bus.WEN}, 32'd0);
      chk("writes_drained", exp_q.size(), 32'd0);
    end

    // Empty image: straight to RUN, no memory traffic while halt is low
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    tick();
    tick();
    chk("n0_tbCTRL", {31'd0, bus.tbCTRL}, 32'd0);
    repeat (6) tick();
    chk("n0_state", {28'd0, dbgState}, {28'd0, S_RUN});
    chk("n0_ren", {31'd0, bus.REN}, 32'd0);
    chk("n0_no_writes", exp_q.size(), 32'd0);

    // Reset in the middle of a word, then a fresh image
    do_reset();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    do_reset();
    exp_q.push_back({LOAD_BASE_P, 32'hCAFEF00D});
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'hCAFEF00D, 1'b0, 1'b1);
    tick();
    tick();
    chk("fresh_writes_drained", exp_q.size(), 32'd0);
    chk("fresh_mem", mem[LOAD_BASE_P[11:2]], 32'hCAFEF00D);

    // Dump with halt already high during the load, RD_LAT=2, stalled tx
    do_reset();
    bus.halt = 1'b1;
    exp_q.push_back({LOAD_BASE_P, 32'h11223344});
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'h11223344, 1'b0, 1'b1);
    tick();
    chk("halt_run_tbCTRL", {31'd0, bus.tbCTRL}, 32'd0);
    tick();
    chk("halt_run_one_cycle", {28'd0, dbgState}, {28'd0, S_DUMP_RD});
    foreach (tx_q[i]) tx_q.delete(i);
    tx_q.push_back(8'hDD); tx_q.push_back(8'hCC);
    tx_q.push_back(8'hBB); tx_q.push_back(8'hAA);
    tx_q.push_back(8'h04); tx_q.push_back(8'h03);
    tx_q.push_back(8'h02); tx_q.push_back(8'h01);
`ifdef SYS_LOADER_CSUM_EN
    tx_q.push_back(8'h04);
    nb = 9;
`else
    nb = 8;
`endif
    for (int k = 0; k < nb; k++) begin
      n = 0;
      while (!bus.tx_valid && n < 100) begin
        tick();
        n++;
      end
      if (!bus.tx_valid) begin
        chk("tx_timeout", 32'd0, 32'd1);
        break;
      end
      d0 = bus.tx_data;
      repeat (3) begin
        tick();
        chk("tx_stable", {24'd0, bus.tx_data}, {24'd0, d0});
        chk("tx_valid_held", {31'd0, bus.tx_valid}, 32'd1);
      end
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
    end
    tick();
    chk("tx_drained", tx_q.size(), 32'd0);
    chk("dump_done", {31'd0, done}, 32'd1);
    chk("dump_state", {28'd0, dbgState}, {28'd0, S_DONE});
    chk("dump_tbCTRL", {31'd0, bus.tbCTRL}, 32'd1);
    bus.halt = 1'b0;
    repeat (5) tick();
    chk("done_sticky", {31'd0, done}, 32'd1);
    chk("done_tx_idle", {31'd0, bus.tx_valid}, 32'd0);
    chk("rd_count", exp_rd, DUMP_BASE_P + 32'(4 * DUMP_WORDS_P));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
